// File: rtl/fetch_predict_stage.sv
// Fetch stage with a direct-mapped branch target buffer (2-bit counters),
// next-PC selection, F/D pipeline register and branch performance counters.
module fetch_predict_stage #(
    parameter int unsigned       XLEN        = 32,
    parameter int unsigned       BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0]   RESET_PC    = '0,
    parameter int unsigned       CNT_WIDTH   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic [XLEN-1:0]      InstrF,
    input  logic                 BrValidE,
    input  logic [XLEN-1:0]      PCE,
    input  logic [XLEN-1:0]      TargetE,
    input  logic                 TakenE,
    input  logic                 PredTakenE,
    input  logic [XLEN-1:0]      PredTargetE,
    output logic [XLEN-1:0]      PCF,
    output logic [XLEN-1:0]      InstrD,
    output logic [XLEN-1:0]      PCD,
    output logic [XLEN-1:0]      PCPlus4D,
    output logic                 PredTakenD,
    output logic [XLEN-1:0]      PredTargetD,
    output logic                 MispredictE,
    output logic [CNT_WIDTH-1:0] BranchCount,
    output logic [CNT_WIDTH-1:0] MispredCount
);

    localparam int unsigned     IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned     TAGW = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);

    logic            btb_valid  [BTB_ENTRIES];
    logic [1:0]      btb_cnt    [BTB_ENTRIES];
    logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0] btb_target [BTB_ENTRIES];

    logic [IDX-1:0]  idx_f;
    logic [IDX-1:0]  idx_e;
    logic [TAGW-1:0] tag_f;
    logic [TAGW-1:0] tag_e;
    logic            hit_f;
    logic            hit_e;
    logic            pred_taken_f;
    logic [XLEN-1:0] pred_target_f;
    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] pc_plus4_e;
    logic [XLEN-1:0] next_pc;

    // BTB lookup at PCF and at PCE, both on pre-edge contents
    always_comb begin
        idx_f         = PCF[IDX+1:2];
        tag_f         = PCF[XLEN-1:IDX+2];
        idx_e         = PCE[IDX+1:2];
        tag_e         = PCE[XLEN-1:IDX+2];
        pc_plus4_f    = PCF + XLEN'(4);
        pc_plus4_e    = PCE + XLEN'(4);
        hit_f         = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
        hit_e         = btb_valid[idx_e] && (btb_tag[idx_e] == tag_e);
        pred_taken_f  = hit_f && btb_cnt[idx_f][1];
        // Predicted next-fetch address carried with the instruction
        pred_target_f = pred_taken_f ? btb_target[idx_f] : pc_plus4_f;
    end

    // Resolve misprediction in Execute and pick the next fetch PC
    always_comb begin
        MispredictE = BrValidE &&
                      ((TakenE != PredTakenE) ||
                       (TakenE && PredTakenE && (TargetE != PredTargetE)));
        if (MispredictE)
            next_pc = TakenE ? TargetE : pc_plus4_e;
        else if (StallF)
            next_pc = PCF;
        else if (pred_taken_f)
            next_pc = btb_target[idx_f];
        else
            next_pc = pc_plus4_f;
    end

    // Fetch PC register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            PCF <= RESET_PC;
        else
            PCF <= next_pc;
    end

    // F/D pipeline register; flush (incl. redirect) overrides stall
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            InstrD      <= NOP;
            PCD         <= '0;
            PCPlus4D    <= '0;
            PredTakenD  <= 1'b0;
            PredTargetD <= '0;
        end else if (FlushD || MispredictE) begin
            InstrD      <= NOP;
            PCD         <= '0;
            PCPlus4D    <= '0;
            PredTakenD  <= 1'b0;
            PredTargetD <= '0;
        end else if (!StallD) begin
            InstrD      <= InstrF;
            PCD         <= PCF;
            PCPlus4D    <= pc_plus4_f;
            PredTakenD  <= pred_taken_f;
            PredTargetD <= pred_target_f;
        end
    end

    // BTB valid bits and saturating direction counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_cnt[i]   <= 2'b01;
            end
        end else if (BrValidE) begin
            if (hit_e) begin
                if (TakenE) begin
                    if (btb_cnt[idx_e] != 2'b11)
                        btb_cnt[idx_e] <= btb_cnt[idx_e] + 2'd1;
                end else begin
                    if (btb_cnt[idx_e] != 2'b00)
                        btb_cnt[idx_e] <= btb_cnt[idx_e] - 2'd1;
                end
            end else if (TakenE) begin
                btb_valid[idx_e] <= 1'b1;
                btb_cnt[idx_e]   <= 2'b10;
            end
        end
    end

    // BTB tag/target storage; no reset needed since valid gates every use.
    // A taken hit rewrites the same tag, so tag and target share one enable.
    always_ff @(posedge CLK) begin
        if (!RST && BrValidE && TakenE) begin
            btb_tag[idx_e]    <= tag_e;
            btb_target[idx_e] <= TargetE;
        end
    end

    // Saturating branch and mispredict performance counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BranchCount  <= '0;
            MispredCount <= '0;
        end else begin
            if (BrValidE && (BranchCount != '1))
                BranchCount <= BranchCount + CNT_WIDTH'(1);
            if (MispredictE && (MispredCount != '1))
                MispredCount <= MispredCount + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Bench for fetch_predict_stage: directed scenarios followed by random
// stimulus, all checked against a behavioural model of fetch and the BTB.
module tb_fetch_predict_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        RST;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrF;
    logic        BrValidE;
    logic [31:0] PCE;
    logic [31:0] TargetE;
    logic        TakenE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        PredTakenD;
    logic [31:0] PredTargetD;
    logic        MispredictE;
    logic [3:0]  BranchCount;
    logic [3:0]  MispredCount;

    fetch_predict_stage #(
        .XLEN(32),
        .BTB_ENTRIES(16),
        .RESET_PC(32'h0),
        .CNT_WIDTH(4)
    ) dut (
        .CLK(CLK), .RST(RST), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .InstrF(InstrF), .BrValidE(BrValidE), .PCE(PCE), .TargetE(TargetE),
        .TakenE(TakenE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .PredTakenD(PredTakenD), .PredTargetD(PredTargetD),
        .MispredictE(MispredictE), .BranchCount(BranchCount),
        .MispredCount(MispredCount)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Model: each BTB slot remembers the full PC of the branch that owns it
    logic [31:0] m_pc;
    bit          m_valid [16];
    logic [31:0] m_owner [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];
    logic [31:0] m_instr, m_pcd, m_pc4d, m_ptgtd;
    bit          m_ptkd;
    int          m_bc, m_mc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit owns(input logic [31:0] pc);
        return m_valid[slot(pc)] && ((m_owner[slot(pc)] >> 2) == (pc >> 2));
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
        end
        m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_ptgtd = 0; m_ptkd = 0;
        m_bc = 0; m_mc = 0;
    endtask

    task automatic check_regs();
        chk("PCF", PCF, m_pc);
        chk("InstrD", InstrD, m_instr);
        chk("PCD", PCD, m_pcd);
        chk("PCPlus4D", PCPlus4D, m_pc4d);
        chk("PredTakenD", {31'b0, PredTakenD}, {31'b0, m_ptkd});
        if (m_ptkd) chk("PredTargetD", PredTargetD, m_ptgtd);
        chk("BranchCount", {28'b0, BranchCount}, 32'(m_bc));
        chk("MispredCount", {28'b0, MispredCount}, 32'(m_mc));
    endtask

    task automatic set_in(input bit brv, input logic [31:0] pce, input bit tk,
                          input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                          input bit sf, input bit sd, input bit fd);
        BrValidE = brv; PCE = pce; TakenE = tk; TargetE = tgt;
        PredTakenE = ptk; PredTargetE = ptgt;
        StallF = sf; StallD = sd; FlushD = fd;
    endtask

    // One clock: check the redirect before the edge, advance the model, check after
    task automatic cycle();
        bit          misp, ptaken;
        logic [31:0] ptgt, npc;
        int          s;
        #2;
        misp = BrValidE && ((TakenE != PredTakenE) ||
                            (TakenE && PredTakenE && (TargetE != PredTargetE)));
        chk("MispredictE", {31'b0, MispredictE}, {31'b0, misp});
        chk("PCF_pre", PCF, m_pc);
        ptaken = owns(m_pc) && (m_cnt[slot(m_pc)] >= 2);
        ptgt   = ptaken ? m_tgt[slot(m_pc)] : m_pc + 32'd4;
        if (misp)         npc = TakenE ? TargetE : PCE + 32'd4;
        else if (StallF)  npc = m_pc;
        else if (ptaken)  npc = m_tgt[slot(m_pc)];
        else              npc = m_pc + 32'd4;
        if (FlushD || misp) begin
            m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_ptkd = 0; m_ptgtd = 0;
        end else if (!StallD) begin
            m_instr = InstrF; m_pcd = m_pc; m_pc4d = m_pc + 32'd4;
            m_ptkd = ptaken; m_ptgtd = ptgt;
        end
        if (BrValidE) begin
            s = slot(PCE);
            if (owns(PCE)) begin
                if (TakenE) begin
                    m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
                    m_tgt[s] = TargetE;
                end else begin
                    m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
                end
            end else if (TakenE) begin
                m_valid[s] = 1'b1; m_owner[s] = PCE; m_tgt[s] = TargetE; m_cnt[s] = 2;
            end
            if (m_bc < 15) m_bc++;
        end
        if (misp && m_mc < 15) m_mc++;
        m_pc = npc;
        @(posedge CLK);
        #1;
        check_regs();
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
    endtask

    // Force PCF to a given address via a not-taken resolve that was predicted taken
    task automatic redirect_to(input logic [31:0] a);
        set_in(1, a - 32'd4, 0, 0, 1, 0, 0, 0, 0);
        cycle();
    endtask

    logic [31:0] pcs  [5] = '{32'h40, 32'h80, 32'h44, 32'h48, 32'h8C};
    logic [31:0] tgts [6] = '{32'h40, 32'h80, 32'h48, 32'h100, 32'h8C, 32'hFFFF_FFFC};

    initial begin
        logic [31:0] rp, rt;
        bit          ptk;
        logic [31:0] ptg;

        RST = 1'b1;
        InstrF = 32'h0050_0093;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge CLK);
        #1;
        check_regs();
        chk("reset_PCF", PCF, 32'h0);
        chk("reset_InstrD", InstrD, NOP);
        RST = 1'b0;

        // Straight-line fetch after reset release
        cycle();
        chk("seq_PCF4", PCF, 32'h4);
        chk("seq_InstrD", InstrD, 32'h0050_0093);
        chk("seq_PCD", PCD, 32'h0);
        cycle();
        chk("seq_PCF8", PCF, 32'h8);

        // Taken branch at 0x40 predicted not-taken: redirect and allocate
        set_in(1, 32'h40, 1, 32'h100, 0, 0, 0, 0, 0);
        #2 chk("alloc_misp", {31'b0, MispredictE}, 32'h1);
        cycle();
        chk("alloc_PCF", PCF, 32'h100);
        chk("alloc_flush", InstrD, NOP);
        redirect_to(32'h40);
        idle();
        chk("hit_PCF", PCF, 32'h100);
        chk("hit_PredTakenD", {31'b0, PredTakenD}, 32'h1);
        chk("hit_PredTargetD", PredTargetD, 32'h100);

        // Three not-taken resolves drive the counter to strongly not-taken
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
        redirect_to(32'h40);
        idle();
        chk("nt_PCF", PCF, 32'h44);
        chk("nt_PredTakenD", {31'b0, PredTakenD}, 32'h0);

        // Redirect wins over both stalls
        set_in(1, 32'h3C, 0, 0, 1, 0, 1, 1, 0);
        cycle();
        chk("stall_redirect_PCF", PCF, 32'h40);
        chk("stall_redirect_InstrD", InstrD, NOP);

        // Aliasing: 0x80 shares the slot of 0x40 and evicts it
        set_in(1, 32'h80, 1, 32'h200, 0, 0, 0, 0, 0);
        cycle();
        redirect_to(32'h40);
        idle();
        chk("alias_old_miss", PCF, 32'h44);
        redirect_to(32'h80);
        idle();
        chk("alias_new_hit", PCF, 32'h200);

        // PC wraps modulo 2^32
        set_in(1, 32'h500, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        cycle();
        chk("wrap_top", PCF, 32'hFFFF_FFFC);
        idle();
        chk("wrap_zero", PCF, 32'h0);

        // Stall with flush resolves as flush
        InstrF = 32'h1234_5678;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        chk("stall_flush_InstrD", InstrD, NOP);

        // Twenty mispredicts saturate the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            set_in(1, 32'h600, 1, 32'h700, 0, 0, 0, 0, 0);
            cycle();
        end
        chk("sat_MispredCount", {28'b0, MispredCount}, 32'hF);
        chk("sat_BranchCount", {28'b0, BranchCount}, 32'hF);

        // Asynchronous reset in the middle of a branch update
        set_in(1, 32'h80, 1, 32'h900, 0, 0, 0, 0, 0);
        #2 RST = 1'b1;
        #1;
        model_reset();
        check_regs();
        chk("midrst_PCF", PCF, 32'h0);
        chk("midrst_MispredCount", {28'b0, MispredCount}, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle();
        chk("post_rst_PCD", PCD, 32'h0);
        redirect_to(32'h80);
        idle();
        chk("post_rst_btb_clear", PCF, 32'h84);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            InstrF = $urandom;
            rp = pcs[$urandom_range(0, 4)];
            rt = tgts[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 1) begin
                ptk = owns(rp) && (m_cnt[slot(rp)] >= 2);
                ptg = ptk ? m_tgt[slot(rp)] : 32'h0;
            end else begin
                ptk = 1'($urandom_range(0, 1));
                ptg = tgts[$urandom_range(0, 5)];
            end
            set_in(1'($urandom_range(0, 2) == 0), rp, 1'($urandom_range(0, 1)), rt, ptk, ptg,
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 7) == 0));
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_predict_stage.md
FETCH_PREDICT_STAGE -- requirements
Module: fetch_predict_stage

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath/PC width; BTB_ENTRIES, default 16, BTB depth (power of 2, >=2); RESET_PC, default 0, PC after reset; CNT_WIDTH, default 16, performance counter width.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 StallF  in  1  hold PCF.
REQ-005 StallD  in  1  hold the F/D register.
REQ-006 FlushD  in  1  clear the F/D register to bubble.
REQ-007 InstrF  in  XLEN  instruction memory read data for PCF.
REQ-008 BrValidE  in  1  instruction in Execute is branch/jump, outcome resolved this cycle.
REQ-009 PCE, TargetE  in  XLEN each  Execute PC and resolved target.
REQ-010 TakenE  in  1  resolved direction.
REQ-011 PredTakenE, PredTargetE  in  1, XLEN  prediction carried down the pipe with the instruction.
REQ-012 PCF  out  XLEN  fetch PC.
REQ-013 InstrD, PCD, PCPlus4D  out  XLEN each  F/D register contents.
REQ-014 PredTakenD, PredTargetD  out  1, XLEN  prediction made for InstrD.
REQ-015 MispredictE  out  1  redirect; the hazard unit uses it to flush Decode and Execute.
REQ-016 BranchCount, MispredCount  out  CNT_WIDTH each  performance counters.

Function
REQ-017 BTB entry SHALL hold valid, tag PC[XLEN-1:IDX+2], target XLEN, 2-bit counter; IDX = log2(BTB_ENTRIES); index = PC[IDX+1:2].
REQ-018 Lookup SHALL be combinational on PCF: hit = valid & tag match; predict taken = hit & counter[1].
REQ-019 Next-PC priority SHALL be:
- MispredictE: TakenE ? TargetE : PCE+4, regardless of StallF.
- else StallF: hold.
- else predicted taken: BTB target.
- else PCF+4.
REQ-020 MispredictE SHALL equal BrValidE & ((TakenE != PredTakenE) | (TakenE & PredTakenE & TargetE != PredTargetE)); combinational, zero latency.
REQ-021 F/D register SHALL load InstrF, PCF, PCF+4, prediction, unless StallD.
REQ-022 FlushD or MispredictE SHALL clear F/D regardless of StallD:
- InstrD = 32'h00000013 (NOP).
- PCD, PCPlus4D, PredTargetD = 0.
- PredTakenD = 0.
REQ-023 On BrValidE with BTB hit at PCE, the counter SHALL increment on taken and decrement on not-taken, saturating at 2'b11 and 2'b00; the target SHALL be written with TargetE when taken.
REQ-024 On BrValidE, miss, TakenE=1: the entry SHALL be allocated (overwriting any occupant) with valid=1, tag, TargetE, counter=2'b10.
REQ-025 On BrValidE, miss, TakenE=0: the BTB SHALL NOT change.
REQ-026 When a same-cycle lookup and update hit the same index, the lookup SHALL use pre-edge contents; the update SHALL be visible from the next cycle.
REQ-027 BranchCount SHALL increment on each BrValidE cycle; MispredCount SHALL increment on each MispredictE cycle; both SHALL saturate at all-ones.
REQ-028 PC arithmetic SHALL be modulo 2^XLEN; PCF = all-ones-minus-3 SHALL wrap to 0.
REQ-029 Stall and flush on the same cycle SHALL resolve as flush.

Reset
REQ-030 While RST=1, state SHALL be: PCF=RESET_PC; F/D as in REQ-022; all BTB valid=0, counters=2'b01; both counters 0.
REQ-031 RST asserted mid-operation SHALL discard in-flight prediction/update that cycle; the first fetch after release SHALL be RESET_PC.
REQ-032 BTB targets/tags SHALL NOT require reset.

Verification
REQ-033 Reset release, InstrF=0x00500093, no stalls -> PCF 0,4,8; InstrD=0x00500093, PCD=0 one cycle after PCF=0.
REQ-034 BrValidE, PCE=0x40, TakenE=1, TargetE=0x100, PredTakenE=0 -> MispredictE=1, next PCF=0x100, InstrD=NOP; later PCF=0x40 -> predicts 0x100, PredTakenD=1.
REQ-035 Three not-taken resolves at 0x40 after allocation -> counter 10->01->00->00; PCF=0x40 then predicts 0x44.
REQ-036 StallF=StallD=1 and MispredictE=1 same cycle -> PCF redirected, F/D flushed to NOP.
REQ-037 Aliasing: taken allocation at 0x40 then taken at 0x80 (BTB_ENTRIES=16, same index) -> 0x40 no longer hits, 0x80 hits.
REQ-038 CNT_WIDTH=4, 20 mispredicts -> MispredCount holds 0xF.
